// File: rtl/power_pipe_pkg.sv
// Shared definitions for the x^POWER pipeline: limits, the per-stage record and a legality check.
package power_pipe_pkg;

   localparam int MAX_POWER = 8;
   localparam int MAX_WIDTH = 32;

   // Fields are sized for the widest legal build; narrower builds keep the upper bits at zero.
   typedef struct packed {
      logic                 valid;
      logic [MAX_WIDTH-1:0] x;
      logic [MAX_WIDTH-1:0] p;
      logic                 ovf;
   } stage_t;

   function automatic bit width_ok(input int w);
      return (w >= 2) && (w <= MAX_WIDTH);
   endfunction

endpackage

// File: rtl/power_pipe_stage.sv
// One multiply stage of power_pipe: p_out = p_in * x_in, overflow detect, enable-gated register.
module power_pipe_stage
   import power_pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic   i_clk,
   input  logic   i_srstN,
   input  logic   i_adv,
   input  stage_t i_prev,
   output stage_t o_stage
);

   localparam logic [MAX_WIDTH-1:0] LOW_MASK = MAX_WIDTH'((64'd1 << WIDTH) - 64'd1);

   logic [2*MAX_WIDTH-1:0] prod_p0;
   logic [2*MAX_WIDTH-1:0] hi_p0;

   // Operands are below 2^WIDTH, so anything above bit WIDTH-1 of the product is overflow.
   always_comb begin
      prod_p0 = {{MAX_WIDTH{1'b0}}, i_prev.p} * {{MAX_WIDTH{1'b0}}, i_prev.x};
      hi_p0   = prod_p0 >> WIDTH;
   end

   // ---- stage register ----
   always_ff @(posedge i_clk) begin
      if (!i_srstN) begin
         o_stage <= '0;
      end else if (i_adv) begin
         o_stage.valid <= i_prev.valid;
         o_stage.x     <= i_prev.x;
         o_stage.p     <= prod_p0[MAX_WIDTH-1:0] & LOW_MASK;
         o_stage.ovf   <= i_prev.ovf | (|hi_p0);
      end
   end

endmodule

// File: rtl/power_pipe.sv
// Pipelined unsigned x^POWER with valid/ready and a global clock enable.
// Define POWER_PIPE_SAT_EN to saturate o_xPower to all-ones on overflow instead of truncating.
module power_pipe
   import power_pipe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int POWER = 3
) (
   input  logic             i_clk,
   input  logic             i_srstN,
   input  logic             i_clkEn,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_x,
   output logic             o_ready,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_xPower,
   output logic             o_ovf
);

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("power_pipe: WIDTH=%0d outside 2..%0d", WIDTH, MAX_WIDTH);
   end
   if ((POWER < 1) || (POWER > MAX_POWER)) begin : g_bad_power
      $error("power_pipe: POWER=%0d outside 1..%0d", POWER, MAX_POWER);
   end

   logic   advance;
   stage_t head_p0;
   stage_t chain [POWER];
   stage_t last;
   logic   unused_bits;

   // The whole pipe stalls together; bubbles are not squeezed out.
   assign advance = i_clkEn & (~o_valid | i_ready);
   assign o_ready = advance;

   // ---- stage 1: capture x as both operand and initial product ----
   always_ff @(posedge i_clk) begin
      if (!i_srstN) begin
         head_p0 <= '0;
      end else if (advance) begin
         head_p0.valid <= i_valid;
         head_p0.x     <= MAX_WIDTH'(i_x);
         head_p0.p     <= MAX_WIDTH'(i_x);
         head_p0.ovf   <= 1'b0;
      end
   end

   assign chain[0] = head_p0;

   // ---- stages 2..POWER ----
   for (genvar k = 1; k < POWER; k++) begin : g_stage
      power_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .i_clk   (i_clk),
         .i_srstN (i_srstN),
         .i_adv   (advance),
         .i_prev  (chain[k-1]),
         .o_stage (chain[k])
      );
   end

   assign last        = chain[POWER-1];
   assign o_valid     = last.valid;
   assign o_ovf       = last.ovf;
   assign unused_bits = ^{last.x, last.p};

`ifdef POWER_PIPE_SAT_EN
   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] val, input logic ovf);
      return ovf ? {WIDTH{1'b1}} : val;
   endfunction

   assign o_xPower = saturate(last.p[WIDTH-1:0], last.ovf);
`else
   assign o_xPower = last.p[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_power_pipe.sv
// Scoreboard bench for power_pipe (WIDTH=8, POWER=3) plus a POWER=1 instance.
module tb_power_pipe;

   localparam int WIDTH = 8;
   localparam int POWER = 3;
   localparam longint unsigned MAXV = (64'd1 << WIDTH) - 64'd1;

   logic             clk;
   logic             srstN;
   logic             clkEn;
   logic             valid;
   logic [WIDTH-1:0] x;
   logic             ready;
   logic             o_ready;
   logic             o_valid;
   logic [WIDTH-1:0] xp;
   logic             ovf;

   logic             p1_valid;
   logic [WIDTH-1:0] p1_x;
   logic             p1_ready;
   logic             p1_o_ready;
   logic             p1_o_valid;
   logic [WIDTH-1:0] p1_xp;
   logic             p1_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   logic [WIDTH:0] sb [$];

   power_pipe #(.WIDTH(WIDTH), .POWER(POWER)) u_dut (
      .i_clk    (clk),
      .i_srstN  (srstN),
      .i_clkEn  (clkEn),
      .i_valid  (valid),
      .i_x      (x),
      .o_ready  (o_ready),
      .o_valid  (o_valid),
      .i_ready  (ready),
      .o_xPower (xp),
      .o_ovf    (ovf)
   );

   power_pipe #(.WIDTH(WIDTH), .POWER(1)) u_p1 (
      .i_clk    (clk),
      .i_srstN  (srstN),
      .i_clkEn  (clkEn),
      .i_valid  (p1_valid),
      .i_x      (p1_x),
      .o_ready  (p1_o_ready),
      .o_valid  (p1_o_valid),
      .i_ready  (p1_ready),
      .o_xPower (p1_xp),
      .o_ovf    (p1_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: exact power in 64 bits, then truncate or saturate.
   function automatic logic [WIDTH:0] model(input int unsigned xv, input int pw);
      longint unsigned t = 1;
      logic            m_ovf;
      logic [WIDTH-1:0] m_val;
      for (int k = 0; k < pw; k++) t = t * longint'(xv);
      m_ovf = (t > MAXV);
      m_val = t[WIDTH-1:0];
`ifdef POWER_PIPE_SAT_EN
      if (m_ovf) m_val = '1;
`endif
      return {m_ovf, m_val};
   endfunction

   // Output side of the scoreboard: every completed handshake pops one expectation.
   always @(negedge clk) begin
      if (srstN && clkEn && ready && o_valid) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output got xp=%0d ovf=%0d with empty scoreboard", xp, ovf);
         end else begin
            logic [WIDTH:0] e;
            e = sb.pop_front();
            if ({ovf, xp} !== e) begin
               n_fail++;
               $display("FAIL scoreboard got xp=%0d ovf=%0d expected xp=%0d ovf=%0d",
                        xp, ovf, e[WIDTH-1:0], e[WIDTH]);
            end
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] v);
      int n = 0;
      valid = 1'b1;
      x     = v;
      @(negedge clk);
      while (!o_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (!o_ready) begin
         n_fail++;
         $display("FAIL send_accept x=%0d o_ready=%0d expected 1", v, o_ready);
      end else begin
         sb.push_back(model(int'(v), POWER));
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   task automatic wait_drain(output bit ok);
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      ok = (sb.size() == 0);
   endtask

   task automatic test_reset();
      srstN = 1'b0; clkEn = 1'b1; ready = 1'b1; valid = 1'b0; x = '0;
      p1_valid = 1'b0; p1_x = '0; p1_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0d expected 0", o_valid); end
      n_tests++;
      if (xp !== '0) begin n_fail++; $display("FAIL reset_xpower got %0d expected 0", xp); end
      n_tests++;
      if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0d expected 0", ovf); end
      n_tests++;
      if (p1_o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_p1_valid got %0d expected 0", p1_o_valid); end
      @(posedge clk);
      #1;
      srstN = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      bit ok;
      send(8'd5);
      lat = 1;
      @(negedge clk);
      while (!o_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      n_tests++;
      if (lat != POWER) begin n_fail++; $display("FAIL latency got %0d expected %0d", lat, POWER); end
      wait_drain(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL basic_drain pending=%0d expected 0", sb.size()); end
   endtask

   task automatic test_ovf();
      bit ok;
      send(8'd7);
      send(8'd0);
      send(8'd1);
      send(8'd255);
      send(8'd6);
      send(8'd2);
      wait_drain(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL ovf_drain pending=%0d expected 0", sb.size()); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      send(8'd2);
      send(8'd3);
      send(8'd4);
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_tests++;
         if (o_valid !== 1'b1 || xp !== 8'd8) begin
            n_fail++;
            $display("FAIL stall_hold cyc=%0d got valid=%0d xp=%0d expected valid=1 xp=8", i, o_valid, xp);
         end
         n_tests++;
         if (o_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready cyc=%0d got %0d expected 0", i, o_ready); end
         @(posedge clk);
         #1;
      end
      ready = 1'b1;
      wait_drain(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL b2b_drain pending=%0d expected 0", sb.size()); end
   endtask

   task automatic test_clken();
      bit ok;
      send(8'd3);
      send(8'd5);
      send(8'd6);
      clkEn = 1'b0;
      valid = 1'b1;
      x     = 8'hAA;
      for (int i = 0; i < 5; i++) begin
         ready = i[0];
         @(negedge clk);
         n_tests++;
         if (o_valid !== 1'b1 || xp !== 8'd27 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_out cyc=%0d got valid=%0d xp=%0d ovf=%0d expected 1/27/0", i, o_valid, xp, ovf);
         end
         n_tests++;
         if (o_ready !== 1'b0) begin n_fail++; $display("FAIL freeze_ready cyc=%0d got %0d expected 0", i, o_ready); end
         @(posedge clk);
         #1;
      end
      valid = 1'b0;
      ready = 1'b1;
      clkEn = 1'b1;
      wait_drain(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL clken_drain pending=%0d expected 0", sb.size()); end
   endtask

   task automatic test_srst();
      bit ok;
      send(8'd9);
      send(8'd10);
      send(8'd11);
      ready = 1'b0;
      srstN = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      srstN = 1'b1;
      ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (o_valid !== 1'b0 || xp !== '0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL srst_clear got valid=%0d xp=%0d ovf=%0d expected 0/0/0", o_valid, xp, ovf);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_tests++;
         if (o_valid !== 1'b0) begin n_fail++; $display("FAIL srst_stale cyc=%0d got valid=%0d expected 0", i, o_valid); end
      end
      @(posedge clk);
      #1;
      send(8'd2);
      wait_drain(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL srst_drain pending=%0d expected 0", sb.size()); end
   endtask

   task automatic test_power1();
      logic [WIDTH:0] e;
      e = model(200, 1);
      p1_valid = 1'b1;
      p1_x     = 8'd200;
      @(negedge clk);
      n_tests++;
      if (p1_o_ready !== 1'b1 || p1_o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL p1_pre got ready=%0d valid=%0d expected 1/0", p1_o_ready, p1_o_valid);
      end
      @(posedge clk);
      #1;
      p1_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (p1_o_valid !== 1'b1 || {p1_ovf, p1_xp} !== e) begin
         n_fail++;
         $display("FAIL p1_result got valid=%0d xp=%0d ovf=%0d expected 1/%0d/%0d",
                  p1_o_valid, p1_xp, p1_ovf, e[WIDTH-1:0], e[WIDTH]);
      end
      @(negedge clk);
      n_tests++;
      if (p1_o_valid !== 1'b0) begin n_fail++; $display("FAIL p1_after got valid=%0d expected 0", p1_o_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ovf();
      test_back_to_back();
      test_clken();
      test_srst();
      test_power1();
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/power_pipe.md
POWER_PIPE -- requirements
Module: power_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, legal 2..32.
REQ-002 SHALL have parameter POWER, default 3: exponent N, legal 1..MAX_POWER (8).
REQ-003 SHALL have port i_clk, input, 1: sole clock, all state on rising edge.
REQ-004 SHALL have port i_srstN, input, 1: synchronous reset, active-low.
REQ-005 SHALL have port i_clkEn, input, 1: global clock enable (NiosII custom-instruction style).
REQ-006 SHALL have port i_valid, input, 1: i_x carries a sample.
REQ-007 SHALL have port i_x, input, WIDTH: unsigned operand.
REQ-008 SHALL have port o_ready, output, 1: block accepts a sample this cycle.
REQ-009 SHALL have port o_valid, output, 1: o_xPower/o_ovf hold a result.
REQ-010 SHALL have port i_ready, input, 1: downstream accepts the result.
REQ-011 SHALL have port o_xPower, output, WIDTH: x^POWER, truncated or saturated per REQ-026.
REQ-012 SHALL have port o_ovf, output, 1: true x^POWER exceeds 2^WIDTH-1.

Function
REQ-013 SHALL implement POWER pipeline stages: stage 1 registers x; stage k (2..POWER) registers p_k = p_(k-1) * x_(k-1), with x carried alongside.
REQ-014 SHALL have latency exactly POWER advancing cycles from acceptance to o_valid; POWER=1 is a registered pass-through.
REQ-015 SHALL define advance = i_clkEn & (~o_valid | i_ready); all stage registers, valids and carried x load only on advance, else hold.
REQ-016 SHALL drive o_ready = advance; a sample is accepted when i_valid & o_ready.
REQ-017 SHALL insert a bubble (stage valid 0) when advance is high and i_valid is low; bubbles carry no data requirement.
REQ-018 SHALL hold o_valid, o_xPower and o_ovf stable while o_valid & ~i_ready.
REQ-019 SHALL accept back-to-back samples at one per cycle when i_clkEn=1 and i_ready=1.
REQ-020 SHALL compute each product at full 2*WIDTH width and keep the low WIDTH bits as the stage value.
REQ-021 SHALL set a per-sample overflow bit when any stage product has a nonzero upper WIDTH bits or the incoming overflow bit is set; the bit travels with the sample and appears on o_ovf.
REQ-022 SHALL produce o_ovf=0 for x=0 and x=1 at any POWER.
REQ-023 SHALL freeze entirely (no accept, no output change) when i_clkEn=0, regardless of i_ready.

Reset
REQ-024 SHALL, when i_srstN=0 at a rising edge, clear all stage valids, data and overflow bits to 0, independent of i_clkEn.
REQ-025 SHALL, while in reset, output o_valid=0, o_xPower=0, o_ovf=0; in-flight samples are discarded; first acceptance is possible in the cycle after i_srstN returns high.

Configuration
REQ-026 SHALL, when POWER_PIPE_SAT_EN is defined, output o_xPower = 2^WIDTH-1 for any sample with o_ovf=1; when undefined, output the truncated low WIDTH bits; o_ovf behaviour is identical in both builds.

Structure
REQ-027 SHALL place MAX_POWER, the stage record typedef (valid, x, p, ovf) and a WIDTH-legality check function in package power_pipe_pkg.
REQ-028 SHALL implement one multiply stage as sub-module power_pipe_stage (product, overflow detect, enable-gated register), instantiated POWER-1 times via generate.
REQ-029 SHALL flag illegal WIDTH/POWER at elaboration.

Verification
REQ-030 SHALL cover: WIDTH=8, POWER=3, i_x=5 accepted with i_ready=1 -> o_valid after 3 cycles, o_xPower=125, o_ovf=0.
REQ-031 SHALL cover: WIDTH=8, POWER=3, i_x=7 -> o_ovf=1, o_xPower=87 without POWER_PIPE_SAT_EN, 255 with it.
REQ-032 SHALL cover: stream 2,3,4 back-to-back, i_ready=0 for 4 cycles after first o_valid -> o_xPower holds 8, o_ready=0, then 8,27,64 in order with no loss or duplication.
REQ-033 SHALL cover: i_clkEn=0 for 5 cycles mid-stream -> all outputs frozen, o_ready=0; results resume unchanged.
REQ-034 SHALL cover: i_srstN=0 for 1 cycle with 3 samples in flight -> o_valid=0 next cycle, no stale result ever emitted.
REQ-035 SHALL cover: POWER=1, i_x=200 -> o_xPower=200 one cycle later, o_ovf=0.
